// File: rtl/i_decode_q.sv
// ---------------------------------------------------------------------------
// i_decode_q
//
// Registered instruction-decode stage with a DEPTH-entry queue of decoded
// operations. It sits between i_fetch and i_buffer. Each accepted 32-bit
// instruction is decoded into opcode, funct3, funct6, extended register
// indices and an XLEN-wide immediate, and the decoded record is queued.
// Bit 5 of every register index selects the vector register file.
//
// Parameters
//   XLEN   immediate width (>= 32)
//   DEPTH  queue entries (power of two, >= 2)
//   CNT_W  occupancy counter width (derived)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   flush       drop every queued entry and the current input
//   if_valid    inst carries a valid instruction
//   inst        raw 32-bit instruction
//   if_vacant   stage can accept an instruction this cycle
//   ib_vacant   i_buffer takes the head entry this cycle
//   ib_valid    head entry is valid
//   ib_opt      opcode bits [6:0]
//   ib_funct3   bits [14:12]
//   ib_funct6   bits [31:26]
//   ib_rs1      source register 1 index (bit 5 = vector)
//   ib_rs2      source register 2 index (bit 5 = vector)
//   ib_rd       destination register index (bit 5 = vector)
//   ib_imm      decoded immediate
//   ib_illegal  head entry is an illegal encoding
//   count       current queue occupancy
// ---------------------------------------------------------------------------
module i_decode_q #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [31:0]      inst,
  output logic             if_vacant,
  input  logic             ib_vacant,
  output logic             ib_valid,
  output logic [6:0]       ib_opt,
  output logic [2:0]       ib_funct3,
  output logic [5:0]       ib_funct6,
  output logic [5:0]       ib_rs1,
  output logic [5:0]       ib_rs2,
  output logic [5:0]       ib_rd,
  output logic [XLEN-1:0]  ib_imm,
  output logic             ib_illegal,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] OPCODE_B   = 7'b1100011;
  localparam logic [6:0] OPCODE_L   = 7'b0000011;
  localparam logic [6:0] OPCODE_I   = 7'b0010011;
  localparam logic [6:0] OPCODE_JR  = 7'b1100111;
  localparam logic [6:0] OPCODE_S   = 7'b0100011;
  localparam logic [6:0] OPCODE_R   = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI = 7'b0110111;
  localparam logic [6:0] OPCODE_AUI = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL = 7'b1101111;
  localparam logic [6:0] OPCODE_VA  = 1010111 == 0 ? 7'b0 : 7'b1010111;
  localparam logic [6:0] OPCODE_VL  = 7'b0000111;
  localparam logic [6:0] OPCODE_VS  = 7'b0100111;

  // One queued record: everything i_buffer needs about an instruction.
  typedef struct packed {
    logic            illegal;
    logic [6:0]      opt;
    logic [2:0]      funct3;
    logic [5:0]      funct6;
    logic [5:0]      rs1;
    logic [5:0]      rs2;
    logic [5:0]      rd;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t            dec;
  entry_t            head;
  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;
  logic              legal;

  // Register-index candidates. Scalar forms carry a 0 in bit 5, vector
  // forms a 1. The store-vector data register lives in the rd field bits.
  logic [5:0] rs1_x, rs2_x, rd_x;
  logic [5:0] rs1_v, rs2_v, rd_v, vs_data;

  assign rs1_x   = {1'b0, inst[19:15]};
  assign rs2_x   = {1'b0, inst[24:20]};
  assign rd_x    = {1'b0, inst[11:7]};
  assign rs1_v   = {1'b1, inst[19:15]};
  assign rs2_v   = {1'b1, inst[24:20]};
  assign rd_v    = {1'b1, inst[11:7]};
  assign vs_data = {1'b1, inst[11:7]};

  // Handshakes. A full queue never accepts, even if a pop happens in the
  // same cycle, and flush suppresses both sides.
  assign if_vacant = !rst && (count != CNT_W'(DEPTH));
  assign ib_valid  = (count != '0);
  assign push      = if_valid && if_vacant && !flush;
  assign pop       = ib_valid && ib_vacant && !flush;

  // Decoder. Fields that a format does not use stay zero. Anything not
  // recognised is flagged illegal and loses its register/immediate fields,
  // while the raw opcode/funct bits are kept so the exception path can
  // still report what it saw.
  always_comb begin
    dec        = '0;
    dec.opt    = inst[6:0];
    dec.funct3 = inst[14:12];
    dec.funct6 = inst[31:26];
    legal      = 1'b1;

    unique case (inst[6:0])
      OPCODE_B: begin
        dec.rs1 = rs1_x;
        dec.rs2 = rs2_x;
        dec.imm = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPCODE_L, OPCODE_I, OPCODE_JR: begin
        dec.rs1 = rs1_x;
        dec.rd  = rd_x;
        dec.imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      end
      OPCODE_S: begin
        dec.rs1 = rs1_x;
        dec.rs2 = rs2_x;
        dec.imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPCODE_R: begin
        dec.rs1 = rs1_x;
        dec.rs2 = rs2_x;
        dec.rd  = rd_x;
      end
      OPCODE_LUI, OPCODE_AUI: begin
        dec.rd  = rd_x;
        dec.imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
      end
      OPCODE_JAL: begin
        dec.rd  = rd_x;
        dec.imm = {{(XLEN-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPCODE_VA: begin
        // The vector-arithmetic sub-format is chosen by funct3.
        unique case (inst[14:12])
          3'b111: begin
            dec.rs1 = rs1_x;
            dec.rd  = rd_x;
            dec.imm = {{(XLEN-11){1'b0}}, inst[30:20]};
          end
          3'b000: begin
            dec.rs1 = rs1_v;
            dec.rs2 = rs2_v;
            dec.rd  = rd_v;
          end
          3'b100: begin
            dec.rs1 = rs1_x;
            dec.rs2 = rs2_v;
            dec.rd  = rd_v;
          end
          3'b011: begin
            dec.rs2 = rs2_v;
            dec.rd  = rd_v;
            dec.imm = {{(XLEN-5){inst[19]}}, inst[19:15]};
          end
          default: legal = 1'b0;
        endcase
      end
      OPCODE_VL: begin
        dec.rs1 = rs1_x;
        dec.rd  = rd_v;
      end
      OPCODE_VS: begin
        dec.rs1 = rs1_x;
        dec.rs2 = vs_data;
      end
      default: legal = 1'b0;
    endcase

    // Compressed/short encodings are outside this stage's instruction set.
    if (inst[1:0] != 2'b11) begin
      legal = 1'b0;
    end

    if (!legal) begin
      dec.rs1     = '0;
      dec.rs2     = '0;
      dec.rd      = '0;
      dec.imm     = '0;
      dec.illegal = 1'b1;
    end
  end

  // Queue storage. Entries need no reset: an empty queue forces the
  // outputs to zero, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dec;
    end
  end

  // Pointers and occupancy. Reset beats flush, and flush beats any push or
  // pop in the same cycle. DEPTH is a power of two, so the pointers wrap
  // by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Head presentation: straight from storage, zeroed when nothing is held.
  always_comb begin
    head = '0;
    if (ib_valid) begin
      head = mem[rd_ptr];
    end
  end

  assign ib_opt     = head.opt;
  assign ib_funct3  = head.funct3;
  assign ib_funct6  = head.funct6;
  assign ib_rs1     = head.rs1;
  assign ib_rs2     = head.rs2;
  assign ib_rd      = head.rd;
  assign ib_imm     = head.imm;
  assign ib_illegal = head.illegal;

endmodule

// File: tb/tb_i_decode_q.sv
// ---------------------------------------------------------------------------
// tb_i_decode_q
//
// Self-checking bench for i_decode_q. A queue of expected decoded records,
// built from the instruction-format rules with plain arithmetic, is compared
// against every DUT output once per cycle, mid-cycle.
// ---------------------------------------------------------------------------
module tb_i_decode_q;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             if_valid;
  logic [31:0]      inst;
  logic             if_vacant;
  logic             ib_vacant;
  logic             ib_valid;
  logic [6:0]       ib_opt;
  logic [2:0]       ib_funct3;
  logic [5:0]       ib_funct6;
  logic [5:0]       ib_rs1;
  logic [5:0]       ib_rs2;
  logic [5:0]       ib_rd;
  logic [XLEN-1:0]  ib_imm;
  logic             ib_illegal;
  logic [CNT_W-1:0] count;

  typedef struct {
    logic            illegal;
    logic [6:0]      opt;
    logic [2:0]      f3;
    logic [5:0]      f6;
    logic [5:0]      rs1;
    logic [5:0]      rs2;
    logic [5:0]      rd;
    logic [XLEN-1:0] imm;
  } exp_t;

  exp_t model_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [6:0] opc_tab [13] = '{7'b1100011, 7'b0000011, 7'b0010011, 7'b1100111,
                               7'b0100011, 7'b0110011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b1010111, 7'b1010111, 7'b0000111,
                               7'b0100111};

  i_decode_q #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .if_valid   (if_valid),
    .inst       (inst),
    .if_vacant  (if_vacant),
    .ib_vacant  (ib_vacant),
    .ib_valid   (ib_valid),
    .ib_opt     (ib_opt),
    .ib_funct3  (ib_funct3),
    .ib_funct6  (ib_funct6),
    .ib_rs1     (ib_rs1),
    .ib_rs2     (ib_rs2),
    .ib_rd      (ib_rd),
    .ib_imm     (ib_imm),
    .ib_illegal (ib_illegal),
    .count      (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Interpret an unsigned field of the given width as two's complement.
  function automatic longint sx(input longint raw, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (raw >= half) ? raw - (half << 1) : raw;
  endfunction

  function automatic logic [5:0] reg_ix(input bit vec, input logic [4:0] n);
    return {vec, n};
  endfunction

  // Reference decode straight from the format table, immediates computed
  // as signed integers and then truncated to XLEN.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t   e;
    longint v;
    bit     ok;
    v  = 0;
    ok = 1;
    e.illegal = 0;
    e.opt = w[6:0];
    e.f3  = w[14:12];
    e.f6  = w[31:26];
    e.rs1 = 0;
    e.rs2 = 0;
    e.rd  = 0;
    case (w[6:0])
      7'b1100011: begin
        e.rs1 = reg_ix(0, w[19:15]);
        e.rs2 = reg_ix(0, w[24:20]);
        v = sx((longint'(w[31]) << 12) + (longint'(w[7]) << 11) +
               (longint'(w[30:25]) << 5) + (longint'(w[11:8]) << 1), 13);
      end
      7'b0000011, 7'b0010011, 7'b1100111: begin
        e.rs1 = reg_ix(0, w[19:15]);
        e.rd  = reg_ix(0, w[11:7]);
        v = sx(longint'(w[31:20]), 12);
      end
      7'b0100011: begin
        e.rs1 = reg_ix(0, w[19:15]);
        e.rs2 = reg_ix(0, w[24:20]);
        v = sx(longint'(w[31:25]) * 32 + longint'(w[11:7]), 12);
      end
      7'b0110011: begin
        e.rs1 = reg_ix(0, w[19:15]);
        e.rs2 = reg_ix(0, w[24:20]);
        e.rd  = reg_ix(0, w[11:7]);
      end
      7'b0110111, 7'b0010111: begin
        e.rd = reg_ix(0, w[11:7]);
        v = sx(longint'(w[31:12]) * 4096, 32);
      end
      7'b1101111: begin
        e.rd = reg_ix(0, w[11:7]);
        v = sx((longint'(w[31]) << 20) + (longint'(w[19:12]) << 12) +
               (longint'(w[20]) << 11) + (longint'(w[30:21]) << 1), 21);
      end
      7'b1010111: begin
        if (w[14:12] == 3'b111) begin
          e.rs1 = reg_ix(0, w[19:15]);
          e.rd  = reg_ix(0, w[11:7]);
          v = longint'(w[30:20]);
        end else if (w[14:12] == 3'b000) begin
          e.rs1 = reg_ix(1, w[19:15]);
          e.rs2 = reg_ix(1, w[24:20]);
          e.rd  = reg_ix(1, w[11:7]);
        end else if (w[14:12] == 3'b100) begin
          e.rs1 = reg_ix(0, w[19:15]);
          e.rs2 = reg_ix(1, w[24:20]);
          e.rd  = reg_ix(1, w[11:7]);
        end else if (w[14:12] == 3'b011) begin
          e.rs2 = reg_ix(1, w[24:20]);
          e.rd  = reg_ix(1, w[11:7]);
          v = sx(longint'(w[19:15]), 5);
        end else begin
          ok = 0;
        end
      end
      7'b0000111: begin
        e.rs1 = reg_ix(0, w[19:15]);
        e.rd  = reg_ix(1, w[11:7]);
      end
      7'b0100111: begin
        e.rs1 = reg_ix(0, w[19:15]);
        e.rs2 = reg_ix(1, w[11:7]);
      end
      default: ok = 0;
    endcase
    if (!ok || w[1:0] != 2'b11) begin
      e.illegal = 1;
      e.rs1 = 0;
      e.rs2 = 0;
      e.rd  = 0;
      v     = 0;
    end
    e.imm = v[XLEN-1:0];
    return e;
  endfunction

  // Mostly-legal random instruction: random upper bits over a real opcode,
  // with an occasional fully random word for the illegal paths.
  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 13) begin
      r[6:0] = opc_tab[k];
    end
    return r;
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model,
  // advance the model by the queue rules, then take the edge.
  task automatic applyStimulus(input bit r, input bit f, input bit v,
                               input logic [31:0] w, input bit iv);
    exp_t h;
    int   n;
    bit   do_pop;
    bit   do_push;
    @(negedge clk);
    rst       = r;
    flush     = f;
    if_valid  = v;
    inst      = w;
    ib_vacant = iv;
    #1;
    n = model_q.size();
    h.illegal = 0; h.opt = 0; h.f3 = 0; h.f6 = 0;
    h.rs1 = 0; h.rs2 = 0; h.rd = 0; h.imm = 0;
    if (n != 0) begin
      h = model_q[0];
    end
    checkOutput("if_vacant",  64'(if_vacant),  64'(!r && n != DEPTH));
    checkOutput("ib_valid",   64'(ib_valid),   64'(n != 0));
    checkOutput("count",      64'(count),      64'(n));
    checkOutput("ib_opt",     64'(ib_opt),     64'(h.opt));
    checkOutput("ib_funct3",  64'(ib_funct3),  64'(h.f3));
    checkOutput("ib_funct6",  64'(ib_funct6),  64'(h.f6));
    checkOutput("ib_rs1",     64'(ib_rs1),     64'(h.rs1));
    checkOutput("ib_rs2",     64'(ib_rs2),     64'(h.rs2));
    checkOutput("ib_rd",      64'(ib_rd),      64'(h.rd));
    checkOutput("ib_imm",     64'(ib_imm),     64'(h.imm));
    checkOutput("ib_illegal", 64'(ib_illegal), 64'(h.illegal));
    if (r || f) begin
      model_q.delete();
    end else begin
      do_pop  = (n != 0) && iv;
      do_push = v && (n != DEPTH);
      if (do_pop) begin
        void'(model_q.pop_front());
      end
      if (do_push) begin
        model_q.push_back(ref_decode(w));
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    if_valid  = 1'b0;
    inst      = '0;
    ib_vacant = 1'b0;
    repeat (2) @(posedge clk);

    // Post-reset state.
    applyStimulus(0, 0, 0, 32'h0, 0);

    // addi x1,x0,5
    applyStimulus(0, 0, 1, 32'h00500093, 1);
    #1;
    checkOutput("addi_valid", 64'(ib_valid), 64'd1);
    checkOutput("addi_rd",    64'(ib_rd),    64'd1);
    checkOutput("addi_rs1",   64'(ib_rs1),   64'd0);
    checkOutput("addi_imm",   64'(ib_imm),   64'd5);
    checkOutput("addi_ill",   64'(ib_illegal), 64'd0);
    checkOutput("addi_count", 64'(count),    64'd1);

    // beq x0,x0,-4
    applyStimulus(0, 0, 1, 32'hFE000EE3, 1);
    #1;
    checkOutput("beq_imm", 64'(ib_imm), 64'hFFFFFFFC);
    checkOutput("beq_rd",  64'(ib_rd),  64'd0);

    // vadd.vv v3,v2,v1
    applyStimulus(0, 0, 1, 32'h022081D7, 1);
    #1;
    checkOutput("vadd_rs1", 64'(ib_rs1), 64'h21);
    checkOutput("vadd_rs2", 64'(ib_rs2), 64'h22);
    checkOutput("vadd_rd",  64'(ib_rd),  64'h23);

    // VA funct3=111: scalar rs1/rd, zero-extended immediate
    applyStimulus(0, 0, 1, 32'h0000F057, 1);
    #1;
    checkOutput("va7_rs1", 64'(ib_rs1), 64'h01);
    checkOutput("va7_rd",  64'(ib_rd),  64'h00);
    checkOutput("va7_imm", 64'(ib_imm), 64'h0);

    // VA funct3=001: illegal
    applyStimulus(0, 0, 1, 32'h00001057, 1);
    #1;
    checkOutput("va1_ill", 64'(ib_illegal), 64'd1);
    checkOutput("va1_opt", 64'(ib_opt),     64'h57);
    applyStimulus(0, 0, 0, 32'h0, 1);

    // Back-pressure: fill to DEPTH, one extra push must be ignored.
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(0, 0, 1, rand_inst(), 0);
    end
    #1;
    checkOutput("full_count",  64'(count),     64'(DEPTH));
    checkOutput("full_vacant", 64'(if_vacant), 64'd0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 1);
    end

    // Flush with three entries held, alongside a push and a pop.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, rand_inst(), 0);
    end
    applyStimulus(0, 1, 1, rand_inst(), 1);
    #1;
    checkOutput("flush_count",  64'(count),     64'd0);
    checkOutput("flush_valid",  64'(ib_valid),  64'd0);
    checkOutput("flush_vacant", 64'(if_vacant), 64'd1);

    // Streaming through pointer wrap.
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      applyStimulus(0, 0, 1, rand_inst(), 1);
    end

    // Reset in the middle of a partly full queue.
    applyStimulus(0, 0, 1, rand_inst(), 0);
    applyStimulus(0, 0, 1, rand_inst(), 0);
    applyStimulus(1, 0, 1, rand_inst(), 1);
    applyStimulus(0, 0, 0, 32'h0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 500; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 3) != 0, rand_inst(),
                    $urandom_range(0, 2) != 0);
    end
    applyStimulus(0, 0, 0, 32'h0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_decode_q.md
# i_decode_q

Registered, parametrised instruction-decode stage with a DEPTH-entry decoded-op queue, sitting between i_fetch and i_buffer. Each accepted 32-bit instruction is decoded into opt, funct3, funct6, extended register indices (bit 5 selects the vector file) and an XLEN-wide immediate, then queued. Compared with the combinational decoder, it adds U/J/JALR formats, illegal-instruction flagging, back-pressure buffering and a flush.

## Interface
- XLEN, 32: immediate width; must be ≥ 32.
- DEPTH, 4: queue entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived).

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all queued entries and the current input.
- if_valid  in  1  inst is valid.
- inst  in  32  raw instruction.
- if_vacant  out  1  stage can accept this cycle.
- ib_vacant  in  1  i_buffer accepts the head entry this cycle.
- ib_valid  out  1  head entry valid.
- ib_opt  out  7  inst[6:0].
- ib_funct3  out  3  inst[14:12].
- ib_funct6  out  6  inst[31:26].
- ib_rs1, ib_rs2, ib_rd  out  6 each  register index; bit 5 = 1 selects a vector register.
- ib_imm  out  XLEN  decoded immediate.
- ib_illegal  out  1  head entry is an illegal encoding.
- count  out  CNT_W  current occupancy.

## Operation
- Push when if_valid && if_vacant && !flush. Pop when ib_valid && ib_vacant && !flush.
- if_vacant = !rst && (count != DEPTH). No push-through when full.
- ib_valid = (count != 0). When empty, all ib_* fields are 0.
- Decode happens before the write; the queue stores decoded fields. Unused rs/rd/imm fields are 0. s-ext means sign-extension to XLEN.
- OPCODE_B 1100011: rs1 = {0,[19:15]}, rs2 = {0,[24:20]}, imm = s-ext {[31],[7],[30:25],[11:8],0}.
- OPCODE_L 0000011, OPCODE_I 0010011 and JALR 1100111: rs1, rd = {0,[11:7]}, imm = s-ext [31:20].
- OPCODE_S 0100011: rs1, rs2, imm = s-ext {[31:25],[11:7]}.
- OPCODE_R 0110011: rs1, rs2, rd.
- LUI 0110111 and AUIPC 0010111: rd, imm = s-ext {[31:12],12'b0}.
- JAL 1101111: rd, imm = s-ext {[31],[19:12],[20],[30:21],0}.
- OPCODE_VA 1010111, by funct3:
  - 111: rs1 scalar, rd scalar, imm = zero-ext [30:20].
  - 000: rs1, rs2, rd all vector.
  - 100: rs1 scalar, rs2 vector, rd vector.
  - 011: rs2 vector, rd vector, imm = s-ext [19:15].
  - Any other funct3: illegal.
- OPCODE_VL 0000111: rs1 scalar, rd vector.
- OPCODE_VS 0100111: rs1 scalar, rs2 = {1,[11:7]}.
- Illegal: unlisted opcode, inst[1:0] != 2'b11, or the VA funct3 case above. Illegal entries are still enqueued with ib_illegal = 1, all register fields 0 and imm 0; opt, funct3 and funct6 keep the raw bits.

## Timing
- Reset (rst = 1 at a clock edge): pointers and count = 0. Next cycle: ib_valid = 0, all fields 0, count = 0. if_vacant is 0 while rst is high and 1 on the first cycle after.
- Latency: an instruction pushed at edge N is visible at the head from cycle N+1 (when the queue was empty). There is no combinational bypass from inst to ib_*.
- Throughput: one push and one pop per cycle. A simultaneous push and pop leaves count unchanged.
- Pointer wrap: read and write pointers wrap modulo DEPTH.
- Flush at edge N: count and pointers go to 0 and no push or pop occurs. In cycle N+1, ib_valid = 0 and if_vacant = 1. Flush beats a simultaneous push and pop.
- Reset has priority over flush. A reset asserted mid-stream drops all entries.
- ib_* are stable while ib_valid && !ib_vacant.

## Test plan
- Reset, then push 0x00500093 (addi x1,x0,5) -> next cycle ib_valid = 1, rd = 6'd1, rs1 = 0, imm = 32'd5, illegal = 0; count = 1.
- Push 0xFE000EE3 (beq x0,x0,-4) -> imm = 0xFFFFFFFC, rs1 = rs2 = 0, rd = 0.
- Push 0x022081D7 (vadd.vv v3,v2,v1) -> rs1 = 6'h21, rs2 = 6'h22, rd = 6'h23. Push 0x0000F057 (VA funct3 = 111) -> rs1, rd scalar, imm zero-extended. Push 0x00001057 (VA funct3 = 001) -> illegal = 1.
- Hold ib_vacant = 0 and push DEPTH instructions -> count = DEPTH, if_vacant = 0, a further if_valid is ignored. Release -> entries drain in order, one per cycle.
- Queue holding 3 entries, assert flush together with if_valid and ib_vacant -> next cycle count = 0, ib_valid = 0, nothing consumed or accepted.
- Continuous if_valid and ib_vacant over 2×DEPTH instructions -> count stays 1 after the first cycle, output order matches input order, and pointer wrap is exercised.
